rggen_apb_host_adapter: RTL and testbench
=========================================

// Module: rggen_apb_host_adapter
// PURPOSE
//  APB4 slave front-end that drives the shared register request bus consumed by every
//  rggen register block (plain and indirect) in a generated register map.
//  Registers one APB transfer, broadcasts it as a single request to all register slaves,
//  then collects ready/select/read_data/status and returns a registered APB response.
//  Sits directly upstream of the per-register decoders: one instance per register map.
// PARAMETERS
//  ADDRESS_WIDTH    16  width of paddr and of the broadcast request address (byte address)
//  DATA_WIDTH       32  APB/register data width; multiple of 8, 8..64
//  TOTAL_REGISTERS   1  number of register slaves on the request bus (>=1)
//  TIMEOUT_CYCLES  255  request cycles before abort (used only with RGGEN_APB_TIMEOUT_EN)
// PORTS
//  clk          in   1                  clock
//  rst_n        in   1                  reset, synchronous, active-low
//  i_psel       in   1                  APB select
//  i_penable    in   1                  APB enable (access phase)
//  i_paddr      in   ADDRESS_WIDTH      APB address
//  i_pwrite     in   1                  1 = write, 0 = read
//  i_pwdata     in   DATA_WIDTH         write data
//  i_pstrb      in   DATA_WIDTH/8       byte strobes, writes only
//  o_pready     out  1                  transfer complete
//  o_prdata     out  DATA_WIDTH         read data, valid with o_pready on reads
//  o_pslverr    out  1                  error response, valid with o_pready
//  register_if  master [TOTAL_REGISTERS] rggen_register_if: drives request, address,
//               direction, write_data, write_mask; samples select, ready, read_data, status
// BEHAVIOUR
//  Reset: state=IDLE; o_pready=0, o_prdata=0, o_pslverr=0, request=0, address/write_data=0,
//   write_mask=0, direction=RGGEN_READ. Applies on the clk edge with rst_n=0, any state.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: psel && !penable (setup phase) -> latch paddr, pwrite, pwdata, mask; go BUSY.
//   BUSY: request=1 to all slaves with latched fields. Exit when any_ready (OR of ready)
//     or no_select (no slave asserts select). Latch response; go DONE.
//   DONE: o_pready=1 for exactly one cycle, o_prdata/o_pslverr held stable; then IDLE.
//     request=0 in DONE. No new setup accepted in DONE; next accept is from IDLE.
//  Latency: setup at cycle 0, request cycle 1 (registers answer combinationally),
//   o_pready cycle 2; slow slaves extend BUSY 1 cycle per wait cycle.
//  write_mask: writes expand pstrb bit i to bits [8i+7:8i]; reads drive all ones.
//  Response: prdata = OR of read_data of slaves with select && ready, 0 on writes.
//   pslverr = 1 if no_select (decode miss), or any selected slave status != RGGEN_OKAY.
//   More than one select (overlapping map) -> read data OR-ed, pslverr=1.
//  psel/penable dropped while BUSY: transfer runs to completion, pready still pulses.
//  Write with pstrb=0: request still issued with mask 0; OKAY response.
//  Reset mid-BUSY: request drops on that edge; no pready is issued for the aborted transfer.
// CONFIGURATION
//  RGGEN_APB_TIMEOUT_EN defined: counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entry
//   to BUSY and counts request cycles; reaching TIMEOUT_CYCLES without ready forces DONE
//   with pslverr=1, prdata=0. The counter saturates and never wraps.
//  Not defined: no counter; BUSY waits on ready indefinitely; TIMEOUT_CYCLES ignored.
// STRUCTURE
//  rggen_rtl_pkg: rggen_direction (RGGEN_READ/RGGEN_WRITE); rggen_status (RGGEN_OKAY,
//   RGGEN_SLAVE_ERROR, RGGEN_DECODE_ERROR); add rggen_host_state enum
//   (RGGEN_HOST_IDLE/BUSY/DONE) here.
//  One sub-module: rggen_response_mux. It combines select/ready/read_data/status across
//   TOTAL_REGISTERS into any_ready, no_select, read_data, error. It is combinational and
//   reusable by other host adapters.
// TESTING
//  1. Read, 1 slave at 0x10 returning 0xDEAD_BEEF: setup cycle 0 -> request cycle 1,
//     pready=1 cycle 2, prdata=0xDEADBEEF, pslverr=0.
//  2. Write 0x1234_5678, pstrb=4'b0101 -> write_mask=0x00FF_00FF, direction=WRITE,
//     single request cycle, pslverr=0.
//  3. Read unmapped 0x3FC with TOTAL_REGISTERS=4 -> no select, pready cycle 2,
//     pslverr=1, prdata=0.
//  4. Slave holds ready low for 3 cycles -> request high 4 cycles, pready on cycle 5,
//     exactly one pready pulse.
//  5. rst_n=0 while BUSY -> next edge request=0, state IDLE; a fresh read then completes normally.
//  6. With RGGEN_APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never ready -> pready after
//     8 request cycles, pslverr=1. Without the macro, request is still high at cycle 100.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register request bus and its host adapters.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RGGEN_HOST_IDLE = 2'b00,
    RGGEN_HOST_BUSY = 2'b01,
    RGGEN_HOST_DONE = 2'b10
  } rggen_host_state;

endpackage

// File: rtl/rggen_register_if.sv
// Request/response bus between a host adapter and one register slave.
interface rggen_register_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  import rggen_rtl_pkg::*;

  logic                     request;
  logic [ADDRESS_WIDTH-1:0] address;
  rggen_direction           direction;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [DATA_WIDTH-1:0]    write_mask;
  logic                     select;
  logic                     ready;
  logic [DATA_WIDTH-1:0]    read_data;
  rggen_status              status;

  modport host (
    output request, address, direction, write_data, write_mask,
    input  select, ready, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_mask,
    output select, ready, read_data, status
  );
endinterface

// File: rtl/rggen_response_mux.sv
// Combines per-register responses into one host response (combinational).
module rggen_response_mux
  import rggen_rtl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1
) (
  input  logic                  i_select    [TOTAL_REGISTERS],
  input  logic                  i_ready     [TOTAL_REGISTERS],
  input  logic [DATA_WIDTH-1:0] i_read_data [TOTAL_REGISTERS],
  input  rggen_status           i_status    [TOTAL_REGISTERS],
  output logic                  o_any_ready,
  output logic                  o_no_select,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_error
);

  logic w_seen;
  logic w_multi;
  logic w_status_err;

  always_comb begin
    o_any_ready  = 1'b0;
    o_read_data  = '0;
    w_seen       = 1'b0;
    w_multi      = 1'b0;
    w_status_err = 1'b0;
    for (int i = 0; i < TOTAL_REGISTERS; i++) begin
      o_any_ready = o_any_ready | i_ready[i];
      // a second select means the map overlaps
      w_multi     = w_multi | (w_seen & i_select[i]);
      w_seen      = w_seen | i_select[i];
      if (i_select[i] && i_ready[i]) begin
        o_read_data = o_read_data | i_read_data[i];
        if (i_status[i] != RGGEN_OKAY) w_status_err = 1'b1;
      end
    end
    o_no_select = ~w_seen;
    o_error     = ~w_seen | w_multi | w_status_err;
  end

endmodule

// File: rtl/rggen_apb_host_adapter.sv
// APB4 slave front-end broadcasting one request to all rggen register slaves.
// Optional request timeout enabled by defining RGGEN_APB_TIMEOUT_EN.
module rggen_apb_host_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic                     i_pwrite,
  input  logic [DATA_WIDTH-1:0]    i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]  i_pstrb,
  output logic                     o_pready,
  output logic [DATA_WIDTH-1:0]    o_prdata,
  output logic                     o_pslverr,
  rggen_register_if.host           register_if [TOTAL_REGISTERS]
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  rggen_host_state          r_state;
  rggen_host_state          w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_address;
  rggen_direction           r_direction;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic [DATA_WIDTH-1:0]    r_write_mask;
  logic [DATA_WIDTH-1:0]    r_prdata;
  logic                     r_pslverr;

  logic                     w_setup;
  logic                     w_exit;
  logic                     w_timeout;
  logic [DATA_WIDTH-1:0]    w_mask;

  logic                     w_select    [TOTAL_REGISTERS];
  logic                     w_ready     [TOTAL_REGISTERS];
  logic [DATA_WIDTH-1:0]    w_read_data [TOTAL_REGISTERS];
  rggen_status              w_status    [TOTAL_REGISTERS];
  logic                     w_any_ready;
  logic                     w_no_select;
  logic                     w_error;
  logic [DATA_WIDTH-1:0]    w_mux_data;

  for (genvar g = 0; g < TOTAL_REGISTERS; g++) begin : g_slave
    assign register_if[g].request    = (r_state == RGGEN_HOST_BUSY);
    assign register_if[g].address    = r_address;
    assign register_if[g].direction  = r_direction;
    assign register_if[g].write_data = r_write_data;
    assign register_if[g].write_mask = r_write_mask;
    assign w_select[g]               = register_if[g].select;
    assign w_ready[g]                = register_if[g].ready;
    assign w_read_data[g]            = register_if[g].read_data;
    assign w_status[g]               = register_if[g].status;
  end

  rggen_response_mux #(
    .DATA_WIDTH      (DATA_WIDTH),
    .TOTAL_REGISTERS (TOTAL_REGISTERS)
  ) u_response_mux (
    .i_select    (w_select),
    .i_ready     (w_ready),
    .i_read_data (w_read_data),
    .i_status    (w_status),
    .o_any_ready (w_any_ready),
    .o_no_select (w_no_select),
    .o_read_data (w_mux_data),
    .o_error     (w_error)
  );

  always_comb begin
    w_mask = '1;
    if (i_pwrite) begin
      for (int i = 0; i < STRB_WIDTH; i++) w_mask[8*i+:8] = {8{i_pstrb[i]}};
    end
  end

`ifdef RGGEN_APB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0] r_count;

  // held at zero outside BUSY, so every transfer starts from a clean count
  always_ff @(posedge clk) begin
    if (!rst_n)                                     r_count <= '0;
    else if (r_state != RGGEN_HOST_BUSY)            r_count <= '0;
    else if (r_count != CNT_WIDTH'(TIMEOUT_CYCLES)) r_count <= r_count + 1'b1;
  end

  assign w_timeout = (r_state == RGGEN_HOST_BUSY) &&
                     (r_count >= CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES has no effect in this build
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_state_next = r_state;
    w_setup      = 1'b0;
    w_exit       = 1'b0;
    case (r_state)
      RGGEN_HOST_IDLE: begin
        if (i_psel && !i_penable) begin
          w_setup      = 1'b1;
          w_state_next = RGGEN_HOST_BUSY;
        end
      end
      RGGEN_HOST_BUSY: begin
        if (w_any_ready || w_no_select || w_timeout) begin
          w_exit       = 1'b1;
          w_state_next = RGGEN_HOST_DONE;
        end
      end
      RGGEN_HOST_DONE: w_state_next = RGGEN_HOST_IDLE;
      default:         w_state_next = RGGEN_HOST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= RGGEN_HOST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_address    <= '0;
      r_direction  <= RGGEN_READ;
      r_write_data <= '0;
      r_write_mask <= '0;
      r_prdata     <= '0;
      r_pslverr    <= 1'b0;
    end else begin
      if (w_setup) begin
        r_address    <= i_paddr;
        r_direction  <= i_pwrite ? RGGEN_WRITE : RGGEN_READ;
        r_write_data <= i_pwdata;
        r_write_mask <= w_mask;
      end
      if (w_exit) begin
        if (w_any_ready || w_no_select) begin
          r_prdata  <= (r_direction == RGGEN_READ) ? w_mux_data : '0;
          r_pslverr <= w_error;
        end else begin
          r_prdata  <= '0;
          r_pslverr <= 1'b1;
        end
      end
    end
  end

  assign o_pready  = (r_state == RGGEN_HOST_DONE);
  assign o_prdata  = r_prdata;
  assign o_pslverr = r_pslverr;

endmodule

// File: tb/tb_rggen_apb_host_adapter.sv
// Randomized APB bench with a transaction-level model of the register map.
module tb_rggen_apb_host_adapter;
  import rggen_rtl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  rggen_register_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) rif [NR] ();

  rggen_apb_host_adapter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_paddr(paddr),
    .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb), .o_pready(pready),
    .o_prdata(prdata), .o_pslverr(pslverr), .register_if(rif)
  );

  always #5 clk = ~clk;

  // register map: 0x10, 0x14, 0x44 and the 0x40..0x4F block (overlaps 0x44)
  function automatic bit hit(input int i, input logic [AW-1:0] a);
    case (i)
      0:       return a == 16'h0010;
      1:       return a == 16'h0014;
      2:       return a == 16'h0044;
      default: return a[15:4] == 12'h004;
    endcase
  endfunction

  int          s_wait [NR];
  logic [DW-1:0] s_data [NR];
  rggen_status s_stat [NR];

  for (genvar i = 0; i < NR; i++) begin : g_slv
    int wcnt;
    always @(posedge clk) wcnt <= rif[i].request ? wcnt + 1 : 0;
    always_comb begin
      rif[i].select    = rif[i].request && hit(i, rif[i].address);
      rif[i].ready     = rif[i].select && (wcnt >= s_wait[i]);
      rif[i].read_data = rif[i].ready ? s_data[i] : 32'h0;
      rif[i].status    = rif[i].ready ? s_stat[i] : RGGEN_OKAY;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction model
  logic [AW-1:0] m_addr;
  bit            m_wr;
  logic [DW-1:0] m_wdata, m_mask, m_data;
  bit            m_err;
  int            m_cycles;

  task automatic model(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                       input logic [3:0] st);
    int nsel, mn;
    m_addr = a; m_wr = wr; m_wdata = wd;
    m_mask = '1;
    if (wr) for (int b = 0; b < 4; b++) m_mask[8*b+:8] = st[b] ? 8'hFF : 8'h00;
    nsel = 0; mn = 1 << 30;
    for (int i = 0; i < NR; i++)
      if (hit(i, a)) begin nsel++; if (s_wait[i] < mn) mn = s_wait[i]; end
    m_data = '0;
    if (nsel == 0) begin
      m_cycles = 1; m_err = 1'b1;
    end else begin
      m_cycles = mn + 1; m_err = (nsel > 1);
      for (int i = 0; i < NR; i++)
        if (hit(i, a) && s_wait[i] == mn) begin
          m_data |= s_data[i];
          if (s_stat[i] != RGGEN_OKAY) m_err = 1'b1;
        end
      if (wr) m_data = '0;
`ifdef RGGEN_APB_TIMEOUT_EN
      if (m_cycles > TO) begin m_cycles = TO; m_err = 1'b1; m_data = '0; end
`endif
    end
  endtask

  // compare process: k counts cycles since the setup cycle of the current transfer
  bit            chk_en = 1'b0;
  int            start_id = 0, seen_id = 0;
  bit            active = 1'b0;
  int            k = 0, req_cnt = 0, rdy_cnt = 0, last_k = 0;
  logic [DW-1:0] last_prdata, last_mask;
  logic          last_pslverr;

  always @(negedge clk) begin
    bit e_req, e_rdy;
    if (!chk_en) begin
      seen_id = start_id; active = 1'b0;
    end else begin
      if (seen_id != start_id) begin
        seen_id = start_id; active = 1'b1; k = 0; req_cnt = 0; rdy_cnt = 0;
      end else if (active) k++;
      e_req = active && k >= 1 && k <= m_cycles;
      e_rdy = active && k == m_cycles + 1;
      check("request", rif[0].request, e_req);
      check("request_bcast", rif[NR-1].request, e_req);
      check("pready", pready, e_rdy);
      if (rif[0].request) req_cnt++;
      if (pready) rdy_cnt++;
      if (e_req) begin
        check("address", rif[0].address, m_addr);
        check("direction", rif[0].direction, m_wr ? RGGEN_WRITE : RGGEN_READ);
        check("write_mask", rif[0].write_mask, m_mask);
        if (m_wr) check("write_data", rif[0].write_data, m_wdata);
        last_mask = rif[0].write_mask;
      end
      if (e_rdy) begin
        check("prdata", prdata, m_data);
        check("pslverr", pslverr, m_err);
        last_k = k; last_prdata = prdata; last_pslverr = pslverr;
        active = 1'b0;
      end
    end
  end

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // mode 0: normal access, 1: psel dropped during BUSY, 2: setup pattern held
  task automatic xfer(input logic [AW-1:0] a, input bit wr, input logic [DW-1:0] wd,
                      input logic [3:0] st, input int mode);
    bit got;
    model(a, wr, wd, st);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = wr; pwdata = wd; pstrb = st;
    start_id++;
    @(posedge clk); #1;
    case (mode)
      1:       psel = 1'b0;
      2:       penable = 1'b0;
      default: penable = 1'b1;
    endcase
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (pready === 1'b1) got = 1'b1;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    if (!got) begin
      check("pready_timeout", 1'b0, 1'b1);
      chk_en = 1'b0;
      reset_pulse();
      chk_en = 1'b1;
    end
  endtask

  task automatic default_map();
    for (int i = 0; i < NR; i++) begin
      s_wait[i] = 0; s_stat[i] = RGGEN_OKAY; s_data[i] = 32'h1111_0000 + i;
    end
    s_data[0] = 32'hDEAD_BEEF;
  endtask

  initial begin
    int pr_cnt;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0;
    default_map();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready", pready, 1'b0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", pslverr, 1'b0);
    check("rst_request", rif[0].request, 1'b0);
    check("rst_address", rif[0].address, 16'h0);
    check("rst_direction", rif[0].direction, RGGEN_READ);
    check("rst_write_data", rif[0].write_data, 32'h0);
    check("rst_write_mask", rif[0].write_mask, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 0);
    check("t1_latency", last_k, 2);
    check("t1_prdata", last_prdata, 32'hDEAD_BEEF);
    check("t1_pslverr", last_pslverr, 1'b0);

    xfer(16'h0014, 1'b1, 32'h1234_5678, 4'b0101, 0);
    check("t2_mask", last_mask, 32'h00FF_00FF);
    check("t2_req_cycles", req_cnt, 1);
    check("t2_pslverr", last_pslverr, 1'b0);

    xfer(16'h03FC, 1'b0, 32'h0, 4'h0, 0);
    check("t3_latency", last_k, 2);
    check("t3_pslverr", last_pslverr, 1'b1);
    check("t3_prdata", last_prdata, 32'h0);

    s_wait[0] = 3;
    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 0);
    check("t4_latency", last_k, 5);
    check("t4_req_cycles", req_cnt, 4);
    check("t4_pready_pulses", rdy_cnt, 1);

    xfer(16'h0044, 1'b0, 32'h0, 4'h0, 0);
    check("overlap_prdata", last_prdata, 32'h1111_0002 | 32'h1111_0003);
    check("overlap_pslverr", last_pslverr, 1'b1);

    xfer(16'h0014, 1'b1, 32'hCAFE_F00D, 4'b0000, 1);
    check("zero_strb_mask", last_mask, 32'h0);
    check("zero_strb_pslverr", last_pslverr, 1'b0);

    // reset while BUSY
    chk_en = 1'b0;
    s_wait[0] = 3;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'h0010; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("t5_req_busy", rif[0].request, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_req_after_rst", rif[0].request, 1'b0);
    check("t5_pready_after_rst", pready, 1'b0);
    @(negedge clk);
    check("t5_no_pready", pready, 1'b0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    s_wait[0] = 0;
    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 0);
    check("t5_fresh_latency", last_k, 2);
    check("t5_fresh_prdata", last_prdata, 32'hDEAD_BEEF);

    // slave that never answers
    s_wait[0] = 1000;
`ifdef RGGEN_APB_TIMEOUT_EN
    xfer(16'h0010, 1'b0, 32'h0, 4'h0, 0);
    check("t6_latency", last_k, TO + 1);
    check("t6_pslverr", last_pslverr, 1'b1);
`else
    chk_en = 1'b0;
    pr_cnt = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'h0010; pwrite = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (c == 1) penable = 1'b1;
      @(negedge clk);
      if (pready) pr_cnt++;
      if (c == 100) check("t6_request_c100", rif[0].request, 1'b1);
    end
    check("t6_no_pready", pr_cnt, 0);
    reset_pulse();
    chk_en = 1'b1;
`endif

    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] a;
      logic [3:0]    st;
      for (int i = 0; i < NR; i++) begin
        s_wait[i] = $urandom_range(0, 3);
        s_data[i] = $urandom;
        case ($urandom_range(0, 4))
          0:       s_stat[i] = RGGEN_SLAVE_ERROR;
          1:       s_stat[i] = RGGEN_DECODE_ERROR;
          default: s_stat[i] = RGGEN_OKAY;
        endcase
      end
      case ($urandom_range(0, 6))
        0: a = 16'h0010;
        1: a = 16'h0014;
        2: a = 16'h0044;
        3: a = 16'h0048;
        4: a = 16'h03FC;
        5: a = 16'h004C;
        default: a = 16'($urandom) & 16'hFFFC;
      endcase
      st = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      xfer(a, 1'($urandom), $urandom, st, $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
